fre_divn_prog: RTL and testbench

FRE_DIVN_PROG -- requirements
Module: fre_divn_prog

---
 rtl/fre_divn_pkg.sv | 7 +
 rtl/fre_divn_cfg.sv | 53 +++++
 rtl/fre_divn_prog.sv | 60 ++++++
 tb/tb_fre_divn_prog.sv | 103 ++++++++++
 4 files changed

// File: rtl/fre_divn_pkg.sv
// fre_divn_pkg: shared state encoding and default sizes for the programmable divider
package fre_divn_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;
  localparam int DEF_CW = 8;
  localparam int DEF_LW = 2;
  localparam int DEF_HW = 3;
endpackage

// File: rtl/fre_divn_cfg.sv
// fre_divn_cfg: config handshake, legality check, shadow register and active lengths
module fre_divn_cfg import fre_divn_pkg::*; #(
  parameter int CW = DEF_CW,
  parameter int LW_DEF = DEF_LW,
  parameter int HW_DEF = DEF_HW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_lw,
  input  logic [CW-1:0] cfg_hw,
  input  logic          i_tick,
  input  logic          i_idle,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic [CW-1:0] o_act_lw,
  output logic [CW-1:0] o_act_hw
);
  logic [CW-1:0] r_sh_lw, r_sh_hw, r_act_lw, r_act_hw;
  logic r_pend, r_err;
  logic w_acc, w_ok;
  assign w_acc = cfg_valid && !r_pend;
  assign w_ok = w_acc && cfg_lw != '0 && cfg_hw != '0;
  assign cfg_ready = !r_pend;
  assign cfg_err = r_err;
  assign o_act_lw = r_act_lw;
  assign o_act_hw = r_act_hw;
  // lengths only move at a period boundary or while idle, so a period never changes shape
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_lw <= '0;
      r_sh_hw <= '0;
      r_act_lw <= CW'(LW_DEF);
      r_act_hw <= CW'(HW_DEF);
      r_pend <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_acc && !w_ok;
      if (w_ok && i_tick) begin
        r_act_lw <= cfg_lw;
        r_act_hw <= cfg_hw;
      end else if (w_ok) begin
        r_sh_lw <= cfg_lw;
        r_sh_hw <= cfg_hw;
        r_pend <= 1'b1;
      end else if (r_pend && (i_tick || i_idle)) begin
        r_act_lw <= r_sh_lw;
        r_act_hw <= r_sh_hw;
        r_pend <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/fre_divn_prog.sv
// fre_divn_prog: divider with programmable low/high phase lengths and period tick
module fre_divn_prog import fre_divn_pkg::*; #(
  parameter int CW = DEF_CW,
  parameter int LW_DEF = DEF_LW,
  parameter int HW_DEF = DEF_HW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_lw,
  input  logic [CW-1:0] cfg_hw,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          out_fre_divn,
  output logic          period_tick
);
  state_t r_state, w_nstate;
  logic [CW-1:0] r_lcnt, r_hcnt, w_nlcnt, w_nhcnt, w_act_lw, w_act_hw;
  logic r_out, w_tick;
  fre_divn_cfg #(.CW(CW), .LW_DEF(LW_DEF), .HW_DEF(HW_DEF)) u_cfg (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_lw(cfg_lw), .cfg_hw(cfg_hw),
    .i_tick(w_tick), .i_idle(r_state == S_IDLE), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .o_act_lw(w_act_lw), .o_act_hw(w_act_hw)
  );
  // gated by en so an abort in the last high cycle does not report a period
  assign w_tick = en && r_state == S_HIGH && r_hcnt == w_act_hw;
  assign period_tick = w_tick;
  assign out_fre_divn = r_out;
  always_comb begin
    w_nstate = S_IDLE;
    w_nlcnt = '0;
    w_nhcnt = '0;
    if (en) begin
      if (r_state == S_LOW && r_lcnt != w_act_lw) begin
        w_nstate = S_LOW;
        w_nlcnt = r_lcnt + CW'(1);
      end else if (r_state == S_LOW || (r_state == S_HIGH && r_hcnt != w_act_hw)) begin
        w_nstate = S_HIGH;
        w_nhcnt = r_state == S_LOW ? CW'(1) : r_hcnt + CW'(1);
      end else begin
        w_nstate = S_LOW;
        w_nlcnt = CW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lcnt <= '0;
      r_hcnt <= '0;
      r_out <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_lcnt <= w_nlcnt;
      r_hcnt <= w_nhcnt;
      r_out <= w_nstate == S_HIGH;
    end
  end
endmodule

// File: tb/tb_fre_divn_prog.sv
// tb_fre_divn_prog: directed scenarios plus random traffic against a period-position model
module tb_fre_divn_prog;
  logic clk = 1'b0, rst, en, cfg_valid, cfg_ready, cfg_err, out_fre_divn, period_tick;
  logic [7:0] cfg_lw, cfg_hw;
  int total = 0, bad = 0;
  bit known = 0, m_run, m_pend, m_err;
  int m_pos, m_alw, m_ahw, m_slw, m_shw;

  fre_divn_prog dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_lw(cfg_lw),
    .cfg_hw(cfg_hw), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .out_fre_divn(out_fre_divn), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // model: a period is m_alw low cycles followed by m_ahw high cycles, m_pos counts through it
  function automatic bit cond(input int mode);
    case (mode)
      0: return m_run && m_pos < m_alw && !m_pend;
      1: return m_run && m_pos == m_alw + m_ahw - 1 && !m_pend;
      2: return m_run && m_pos == m_alw && m_ahw > 1;
      default: return m_run && m_pos == m_alw + 100;
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] l, input logic [7:0] h);
    bit tk, acc, ok;
    rst = r; en = e; cfg_valid = v; cfg_lw = l; cfg_hw = h;
    @(negedge clk);
    tk = m_run && e && m_pos == m_alw + m_ahw - 1;
    if (known) begin
      chk("out", out_fre_divn, m_run && m_pos >= m_alw);
      chk("tick", period_tick, tk);
      chk("ready", cfg_ready, !m_pend);
      chk("err", cfg_err, m_err);
    end
    if (r) begin
      known = 1; m_run = 0; m_pos = 0; m_pend = 0; m_err = 0;
      m_alw = 2; m_ahw = 3; m_slw = 0; m_shw = 0;
    end else begin
      acc = v && !m_pend;
      ok = acc && l != 0 && h != 0;
      m_err = acc && !ok;
      if (ok && tk) begin m_alw = l; m_ahw = h; end
      else if (ok) begin m_slw = l; m_shw = h; m_pend = 1; end
      else if (m_pend && (tk || !m_run)) begin m_alw = m_slw; m_ahw = m_shw; m_pend = 0; end
      if (!e) begin m_run = 0; m_pos = 0; end
      else if (!m_run || tk) begin m_run = 1; m_pos = 0; end
      else m_pos++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  task automatic wait_for(input int mode, input string tag, input int lim);
    int i = 0;
    while (!cond(mode) && i < lim) begin step(0, 1, 0, 0, 0); i++; end
    chk(tag, cond(mode), 1);
  endtask

  initial begin
    rst = 1; en = 0; cfg_valid = 0; cfg_lw = 0; cfg_hw = 0;
    @(posedge clk); #1;
    repeat (3) step(1, 0, 0, 0, 0);
    run(20);
    wait_for(0, "wait_low", 20);
    step(0, 1, 1, 4, 1);
    run(20);
    step(0, 1, 1, 0, 5);
    run(12);
    wait_for(1, "wait_tick", 50);
    step(0, 1, 1, 1, 1);
    run(10);
    step(0, 1, 1, 2, 3);
    run(6);
    wait_for(2, "wait_high", 20);
    repeat (3) step(0, 0, 0, 0, 0);
    run(10);
    wait_for(0, "wait_low2", 20);
    step(0, 1, 1, 255, 255);
    run(1100);
    wait_for(3, "wait_mid", 600);
    step(1, 1, 1, 9, 9);
    run(12);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
